// File: rtl/stack_pop_push_ctrl.sv
// Stack push/pop sequencer for CALL, INT, RET and RTI.
// Owns SP and drives the data-memory port during stack traffic.
module stack_pop_push_ctrl #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] SP_RESET = 'h0FFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              call_in,
    input  logic              int_in,
    input  logic              ret_in,
    input  logic              rti_in,
    input  logic [DATA_W-1:0] pc_h_in,
    input  logic [DATA_W-1:0] pc_l_in,
    input  logic [2:0]        flags_in,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        pop_segment_rti,
    output logic [1:0]        pop_segment_ret,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] sp_out
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_FLG,
        POP_FLG,
        POP_PCL,
        POP_PCH
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] sp;
    logic [DATA_W-1:0] sp_n;
    logic [DATA_W-1:0] sp_p1;
    logic [DATA_W-1:0] sp_m1;
    logic [DATA_W-1:0] pch_q;
    logic [DATA_W-1:0] pcl_q;
    logic [2:0]        flg_q;
    logic              is_int_q;
    logic              is_rti_q;
    logic              take;

    assign sp_p1  = sp + DATA_W'(1);
    assign sp_m1  = sp - DATA_W'(1);
    assign sp_out = sp;
    assign stall  = (state != IDLE);

    // State, SP and operand latches; operands captured when a request wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            sp       <= SP_RESET;
            pch_q    <= '0;
            pcl_q    <= '0;
            flg_q    <= '0;
            is_int_q <= 1'b0;
            is_rti_q <= 1'b0;
        end else begin
            state <= state_n;
            sp    <= sp_n;
            if (take) begin
                pch_q    <= pc_h_in;
                pcl_q    <= pc_l_in;
                flg_q    <= flags_in;
                is_int_q <= int_in;
                is_rti_q <= rti_in & ~int_in;
            end
        end
    end

    // Next-state, SP update and memory-port decode
    always_comb begin
        state_n         = state;
        sp_n            = sp;
        take            = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        pop_segment_rti = 2'b00;
        pop_segment_ret = 2'b00;
        done            = 1'b0;
        unique case (state)
            IDLE: begin
                take = int_in | rti_in | ret_in | call_in;
                if (int_in) begin
                    state_n = PUSH_PCH;
                end else if (rti_in) begin
                    state_n = POP_FLG;
                end else if (ret_in) begin
                    state_n = POP_PCL;
                end else if (call_in) begin
                    state_n = PUSH_PCH;
                end
            end
            PUSH_PCH: begin
                mem_write = 1'b1;
                mem_addr  = sp;
                mem_wdata = pch_q;
                sp_n      = sp_m1;
                state_n   = PUSH_PCL;
            end
            PUSH_PCL: begin
                mem_write = 1'b1;
                mem_addr  = sp;
                mem_wdata = pcl_q;
                sp_n      = sp_m1;
                done      = ~is_int_q;
                state_n   = is_int_q ? PUSH_FLG : IDLE;
            end
            PUSH_FLG: begin
                mem_write = 1'b1;
                mem_addr  = sp;
                mem_wdata = DATA_W'(flg_q);
                sp_n      = sp_m1;
                done      = 1'b1;
                state_n   = IDLE;
            end
            POP_FLG: begin
                mem_read        = 1'b1;
                mem_addr        = sp_p1;
                sp_n            = sp_p1;
                pop_segment_rti = 2'b01;
                state_n         = POP_PCL;
            end
            POP_PCL: begin
                mem_read = 1'b1;
                mem_addr = sp_p1;
                sp_n     = sp_p1;
                if (is_rti_q) begin
                    pop_segment_rti = 2'b10;
                end else begin
                    pop_segment_ret = 2'b10;
                end
                state_n = POP_PCH;
            end
            POP_PCH: begin
                mem_read = 1'b1;
                mem_addr = sp_p1;
                sp_n     = sp_p1;
                done     = 1'b1;
                if (is_rti_q) begin
                    pop_segment_rti = 2'b11;
                end else begin
                    pop_segment_ret = 2'b11;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_pop_push_ctrl.sv
// Bench for stack_pop_push_ctrl: directed and random traffic
// against a queue-of-accesses stack model.
module tb_stack_pop_push_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        call_in, int_in, ret_in, rti_in;
    logic [15:0] pc_h_in, pc_l_in;
    logic [2:0]  flags_in;

    logic [15:0] a_addr, a_wdata, a_sp;
    logic        a_rd, a_wr, a_stall, a_done;
    logic [1:0]  a_srti, a_sret;

    logic [15:0] b_addr, b_wdata, b_sp;
    logic        b_rd, b_wr, b_stall, b_done;
    logic [1:0]  b_srti, b_sret;

    always #5 clk = ~clk;

    stack_pop_push_ctrl #(.DATA_W(16), .SP_RESET(16'h0FFF)) u_dut (
        .clk(clk), .reset(reset),
        .call_in(call_in), .int_in(int_in),
        .ret_in(ret_in), .rti_in(rti_in),
        .pc_h_in(pc_h_in), .pc_l_in(pc_l_in),
        .flags_in(flags_in),
        .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_read(a_rd), .mem_write(a_wr),
        .pop_segment_rti(a_srti), .pop_segment_ret(a_sret),
        .stall(a_stall), .done(a_done), .sp_out(a_sp)
    );

    stack_pop_push_ctrl #(.DATA_W(16), .SP_RESET(16'h0000)) u_wrap (
        .clk(clk), .reset(reset),
        .call_in(call_in), .int_in(int_in),
        .ret_in(ret_in), .rti_in(rti_in),
        .pc_h_in(pc_h_in), .pc_l_in(pc_l_in),
        .flags_in(flags_in),
        .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_read(b_rd), .mem_write(b_wr),
        .pop_segment_rti(b_srti), .pop_segment_ret(b_sret),
        .stall(b_stall), .done(b_done), .sp_out(b_sp)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] off;
        logic [15:0] wdata;
        logic [1:0]  srti;
        logic [1:0]  sret;
        logic        done;
    } acc_t;

    // pend holds the accesses still owed by the sequence in flight;
    // off is the address relative to reset SP, so both instances share it
    acc_t        pend[$];
    logic [15:0] msp;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic acc_t mk(input logic wr, input logic [15:0] off,
                                input logic [15:0] wd, input logic [1:0] srti,
                                input logic [1:0] sret, input logic dn);
        acc_t a;
        a.wr = wr; a.rd = ~wr; a.off = off; a.wdata = wd;
        a.srti = srti; a.sret = sret; a.done = dn;
        return a;
    endfunction

    task automatic check_outputs();
        acc_t        e;
        logic [15:0] ea, eb;
        if (pend.size() != 0) e = pend[0];
        else e = '{wr: 0, rd: 0, off: 0, wdata: 0, srti: 0, sret: 0, done: 0};
        ea = (e.wr | e.rd) ? 16'(e.off + 16'h0FFF) : 16'h0000;
        eb = (e.wr | e.rd) ? e.off : 16'h0000;
        check("mem_write", a_wr, e.wr);
        check("mem_read", a_rd, e.rd);
        check("mem_addr", a_addr, ea);
        check("mem_wdata", a_wdata, e.wr ? e.wdata : 16'h0);
        check("seg_rti", a_srti, e.srti);
        check("seg_ret", a_sret, e.sret);
        check("done", a_done, e.done);
        check("stall", a_stall, pend.size() != 0);
        check("sp_out", a_sp, 16'(msp + 16'h0FFF));
        check("wrap_addr", b_addr, eb);
        check("wrap_write", b_wr, e.wr);
        check("wrap_sp", b_sp, msp);
    endtask

    // One clock: check current outputs, drive inputs, advance model at edge
    task automatic cyc(input logic c, input logic i, input logic r,
                       input logic t, input logic rn);
        logic [15:0] ph, pl, s;
        logic [2:0]  fl;
        check_outputs();
        ph = 16'($urandom); pl = 16'($urandom);
        fl = 3'($urandom_range(0, 7));
        call_in = c; int_in = i; ret_in = r; rti_in = t; reset = rn;
        pc_h_in = ph; pc_l_in = pl; flags_in = fl;
        @(posedge clk);
        s = msp;
        if (!rn) begin
            pend.delete();
            msp = 16'h0000;
        end else if (pend.size() != 0) begin
            acc_t a;
            a = pend.pop_front();
            msp = a.wr ? 16'(msp - 1) : 16'(msp + 1);
        end else if (i) begin
            pend.push_back(mk(1, s, ph, 0, 0, 0));
            pend.push_back(mk(1, 16'(s - 1), pl, 0, 0, 0));
            pend.push_back(mk(1, 16'(s - 2), {13'd0, fl}, 0, 0, 1));
        end else if (t) begin
            pend.push_back(mk(0, 16'(s + 1), 0, 2'b01, 0, 0));
            pend.push_back(mk(0, 16'(s + 2), 0, 2'b10, 0, 0));
            pend.push_back(mk(0, 16'(s + 3), 0, 2'b11, 0, 1));
        end else if (r) begin
            pend.push_back(mk(0, 16'(s + 1), 0, 0, 2'b10, 0));
            pend.push_back(mk(0, 16'(s + 2), 0, 0, 2'b11, 1));
        end else if (c) begin
            pend.push_back(mk(1, s, ph, 0, 0, 0));
            pend.push_back(mk(1, 16'(s - 1), pl, 0, 0, 1));
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b0;
        call_in = 0; int_in = 0; ret_in = 0; rti_in = 0;
        pc_h_in = 0; pc_l_in = 0; flags_in = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        msp = 16'h0000;
        cyc(0, 0, 0, 0, 0);
        idle(1);
        // CALL then RET, then INT then RTI
        cyc(1, 0, 0, 0, 1);
        idle(3);
        cyc(0, 0, 1, 0, 1);
        idle(3);
        cyc(0, 1, 0, 0, 1);
        idle(4);
        cyc(0, 0, 0, 1, 1);
        idle(4);
        // Simultaneous INT+CALL; CALL pulsed mid-sequence
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 1);
        idle(3);
        cyc(0, 0, 1, 1, 1);
        idle(4);
        // Reset while in PUSH_PCL of a CALL
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        idle(2);
        // Wrap on the SP_RESET=0 instance: second write lands at FFFF
        cyc(1, 0, 0, 0, 1);
        idle(3);
        cyc(0, 0, 1, 0, 1);
        idle(3);
        // Random traffic
        for (int k = 0; k < 800; k++) begin
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                $urandom_range(0, 63) != 0);
        end
        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
